// File: rtl/ifmap_loader.sv
// Byte-stream frame loader: assembles image or filter frames into registered 2-D arrays and
// holds a completed image until the downstream pipeline acknowledges it.
module ifmap_loader #(
  parameter int unsigned IP_DATA_WIDTH = 8,
  parameter int unsigned IFMAP_SIZE    = 25,
  parameter int unsigned FILTER_SIZE   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IP_DATA_WIDTH-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     s_kind,
  input  logic                     s_last,
  output logic                     s_ready,
  input  logic                     frame_ack,
  output logic [IP_DATA_WIDTH-1:0] ifmap  [IFMAP_SIZE][IFMAP_SIZE],
  output logic [IP_DATA_WIDTH-1:0] filter [FILTER_SIZE][FILTER_SIZE],
  output logic                     ifmap_valid,
  output logic                     filter_valid,
  output logic                     err_len
);

  localparam int unsigned ImgW  = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
  localparam int unsigned FiltW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int unsigned CntW  = (ImgW > FiltW) ? ImgW : FiltW;

  localparam logic [CntW-1:0] ImgLast  = CntW'(IFMAP_SIZE - 1);
  localparam logic [CntW-1:0] FiltLast = CntW'(FILTER_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StLoadImg, StLoadFilt, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] row_q, row_d;
  logic [CntW-1:0] col_q, col_d;
  logic            ifmap_valid_q, ifmap_valid_d;
  logic            filter_valid_q, filter_valid_d;
  logic            err_len_q, err_len_d;

  logic            beat;
  logic            is_filt;
  logic [CntW-1:0] side_last;
  logic            at_last;
  logic            complete;
  logic            early_last;
  logic            img_we;
  logic            filt_we;

  assign beat = s_valid & s_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      row_q          <= '0;
      col_q          <= '0;
      ifmap_valid_q  <= 1'b0;
      filter_valid_q <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      ifmap_valid_q  <= ifmap_valid_d;
      filter_valid_q <= filter_valid_d;
      err_len_q      <= err_len_d;
    end
  end

  // Next-state logic. Counters sit at (0,0) in IDLE, so a 1x1 frame completes on its first beat.
  always_comb begin
    is_filt    = (state_q == StIdle) ? s_kind : (state_q == StLoadFilt);
    side_last  = is_filt ? FiltLast : ImgLast;
    at_last    = (row_q == side_last) && (col_q == side_last);
    complete   = beat && at_last;
    early_last = beat && !at_last && s_last;

    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    ifmap_valid_d  = ifmap_valid_q;
    filter_valid_d = filter_valid_q;
    err_len_d      = (complete && !s_last) || early_last;

    case (state_q)
      StIdle, StLoadImg, StLoadFilt: begin
        if (beat) begin
          if (complete) begin
            state_d = is_filt ? StIdle : StHold;
          end else if (s_last) begin
            state_d = StIdle;
          end else begin
            state_d = is_filt ? StLoadFilt : StLoadImg;
          end
        end
      end
      StHold: begin
        if (frame_ack) begin
          state_d       = StIdle;
          ifmap_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (beat) begin
      if (complete || s_last) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == side_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // A new filter frame invalidates the old one; completion wins for 1x1 frames.
      if ((state_q == StIdle) && s_kind) filter_valid_d = 1'b0;
      if (complete && is_filt) filter_valid_d = 1'b1;
      if (complete && !is_filt) ifmap_valid_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    s_ready = rst && (state_q != StHold);
    filt_we = beat && is_filt;
    img_we  = beat && !is_filt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < IFMAP_SIZE; r++) begin
        for (int c = 0; c < IFMAP_SIZE; c++) begin
          ifmap[r][c] <= '0;
        end
      end
    end else if (img_we) begin
      ifmap[row_q[ImgW-1:0]][col_q[ImgW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          filter[r][c] <= '0;
        end
      end
    end else if (filt_we) begin
      filter[row_q[FiltW-1:0]][col_q[FiltW-1:0]] <= s_data;
    end
  end

  assign ifmap_valid  = ifmap_valid_q;
  assign filter_valid = filter_valid_q;
  assign err_len      = err_len_q;

endmodule

// File: doc/ifmap_loader.md
Name: ifmap_loader

Overview:
- Upstream feeder for the CNN top. Accepts a byte-wide pixel stream with a valid/ready handshake.
- Assembles a full filter frame or image frame into registered 2-D arrays. These drive the convolution's ifmap/filter inputs directly.
- Holds a completed image stable until the downstream pipeline acknowledges consumption, then accepts the next frame.

Parameters:
- IP_DATA_WIDTH, 8, pixel/weight width.
- IFMAP_SIZE, 25, image side length; image frame = IFMAP_SIZE*IFMAP_SIZE beats.
- FILTER_SIZE, 10, filter side length; filter frame = FILTER_SIZE*FILTER_SIZE beats.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  IP_DATA_WIDTH  stream pixel or weight.
- s_valid  in  1  beat valid.
- s_kind  in  1  frame type, sampled on first beat only: 0 = image, 1 = filter.
- s_last  in  1  marks the final beat of a frame.
- s_ready  out  1  loader can accept a beat.
- frame_ack  in  1  downstream has consumed the held image (tie to max_func op_data_valid).
- ifmap  out  [IP_DATA_WIDTH-1:0][IFMAP_SIZE][IFMAP_SIZE]  registered image array.
- filter  out  [IP_DATA_WIDTH-1:0][FILTER_SIZE][FILTER_SIZE]  registered filter array.
- ifmap_valid  out  1  a complete image is held.
- filter_valid  out  1  a complete filter is held.
- err_len  out  1  one-cycle pulse on frame-length violation.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE. Row/col counters = 0.
  - All ifmap and filter entries = 0.
  - ifmap_valid = 0, filter_valid = 0, err_len = 0, s_ready = 0 while rst is low.
  - A reset mid-frame discards the partial frame with no error pulse.
- A beat transfers when s_valid && s_ready at a rising edge.
- s_ready = 1 in IDLE, LOAD_IMG and LOAD_FILT; s_ready = 0 in HOLD.
- State machine:
  - IDLE: the first accepted beat selects the frame type via s_kind.
    - s_kind=1: write filter[0][0], clear filter_valid, go to LOAD_FILT.
    - s_kind=0: write ifmap[0][0], go to LOAD_IMG.
    - The counter advances to (0,1).
  - LOAD_FILT / LOAD_IMG:
    - Each accepted beat writes array[row][col] in row-major order. col increments and wraps to 0 at SIZE-1, then row increments.
    - s_kind is ignored after the first beat.
  - Final-beat handling (beat index SIZE*SIZE-1):
    - Beat carries s_last: frame complete.
    - Beat lacks s_last: frame is still treated as complete and err_len pulses.
    - Completed filter: filter_valid=1 next cycle, return to IDLE.
    - Completed image: ifmap_valid=1 next cycle, go to HOLD.
  - Early s_last (before the final index):
    - Frame aborts and err_len pulses; return to IDLE, counters cleared.
    - Aborted filter: filter_valid stays 0.
    - Aborted image: ifmap_valid stays 0; array contents are don't-care.
  - HOLD:
    - ifmap stays stable and s_ready=0.
    - On frame_ack=1: ifmap_valid=0 next cycle, go to IDLE.
    - frame_ack only takes effect from the first cycle after HOLD is entered. An ack coinciding with the final image beat is ignored.
- frame_ack outside HOLD is ignored.
- filter_valid is sticky across image frames. It is cleared only by reset or by the first beat of a new filter frame.
- Single-frame sizes: a 1x1 frame (SIZE=1) completes on its first beat, IDLE straight to completion.
- Latency:
  - Beat to array update: 1 cycle.
  - Final beat to valid flag: 1 cycle.
  - Ack to s_ready: 1 cycle.
- The arrays are pure registers; no arithmetic. Counter widths are $clog2(SIZE) with a minimum of 1.

Test Plan (IFMAP_SIZE=4, FILTER_SIZE=2):
- Reset then filter frame: 4 beats 1..4, s_kind=1 on the first beat, s_last on the 4th -> filter=[[1,2],[3,4]], filter_valid=1 one cycle after beat 4, err_len never pulses.
- Image frame: 16 beats 0x10..0x1F, s_last on beat 16 -> ifmap[r][c]=0x10+4r+c, ifmap_valid=1, s_ready=0. Further s_valid is not accepted until frame_ack=1 arrives. One cycle later ifmap_valid=0 and s_ready=1.
- Early s_last on image beat 7 -> err_len single-cycle pulse, state IDLE, ifmap_valid=0. The next clean 16-beat frame loads correctly.
- Missing s_last on beat 16 -> err_len pulses; HOLD is still entered with ifmap_valid=1.
- Backpressure and valid gaps: random s_valid gaps during a filter load -> same result as the first scenario. frame_ack pulsed during IDLE/LOAD has no effect.
- Reset mid-image (after 9 beats, rst low for 2 cycles) -> all arrays 0, all valids 0, no err_len. A subsequent full image loads correctly.
